// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
// Access-size encodings, FSM state type and the alignment check.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // The reserved size encoding is reported as misaligned so one check covers both.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Little-endian byte-lane formatting for the data memory.
// Store side builds byte enables and replicated data; load side aligns and extends.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic        is_unsigned,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SIZE_B: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SIZE_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        shifted = raw >> {off, 3'b000};
        rdata   = 32'd0;
        case (size)
            SIZE_B:  rdata = is_unsigned ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  rdata = is_unsigned ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_W:  rdata = raw;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request, one-cycle response pulse,
// sub-word access, configurable load latency and error flagging.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned RD_LAT      = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]  LAT_M1 = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, cur_idx;
    logic [1:0]       off_q, cur_off;
    logic [1:0]       size_q, cur_size;
    logic             uns_q, cur_uns;

    logic             accept, acc_err, out_of_range;
    logic             enter_resp, resp_is_load, resp_err_d;
    logic [31:0]      resp_rdata_d;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data, rd_word, ld_data;

    logic             rsp_valid_q, rsp_err_q;
    logic [31:0]      rsp_rdata_q;

    logic [31:0]      mem [DEPTH_WORDS];

    // In IDLE the live request drives the datapath; in WAIT the captured copy does.
    assign cur_idx  = (state_q == StIdle) ? req_addr[IDX_W+1:2] : idx_q;
    assign cur_off  = (state_q == StIdle) ? req_addr[1:0]       : off_q;
    assign cur_size = (state_q == StIdle) ? req_size            : size_q;
    assign cur_uns  = (state_q == StIdle) ? req_unsigned        : uns_q;

    assign accept       = (state_q == StIdle) && req_valid;
    assign out_of_range = (32'(req_addr[IDX_W+1:2]) >= DEPTH_WORDS) || (|req_addr[31:IDX_W+2]);
    assign acc_err      = misaligned(req_size, req_addr[1:0]) || out_of_range;
    assign rd_word      = mem[cur_idx];

    dmem_lane_fmt u_lane_fmt (
        .size        (cur_size),
        .off         (cur_off),
        .wdata       (req_wdata),
        .is_unsigned (cur_uns),
        .raw         (rd_word),
        .be          (wr_be),
        .wdata_rep   (wr_data),
        .rdata       (ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_we || acc_err || (RD_LAT == 0)) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == StIdle);
        busy      = ~req_ready;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

    // Response data is sampled on the edge that enters RESP; only loads reach WAIT.
    always_comb begin
        enter_resp   = (state_d == StResp);
        resp_is_load = (state_q == StIdle) ? ~req_we : 1'b1;
        resp_err_d   = enter_resp && (state_q == StIdle) && acc_err;
        resp_rdata_d = (enter_resp && resp_is_load && !resp_err_d) ? ld_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= enter_resp;
            rsp_err_q   <= resp_err_d;
            rsp_rdata_q <= resp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q  <= req_addr[IDX_W+1:2];
            off_q  <= req_addr[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned;
        end
    end

    // Array is deliberately outside reset so committed stores survive it.
    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with RD_LAT=0 and one with RD_LAT=3
// sharing clock, reset and request fields.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid0, valid3;
    logic        we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  size;

    logic        ready0, rvalid0, err0, busy0;
    logic [31:0] rdata0;
    logic        ready3, rvalid3, err3, busy3;
    logic [31:0] rdata3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(128), .RD_LAT(0)) u_lat0 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (valid0),
        .req_ready    (ready0),
        .req_we       (we),
        .req_addr     (addr),
        .req_wdata    (wdata),
        .req_size     (size),
        .req_unsigned (uns),
        .rsp_valid    (rvalid0),
        .rsp_rdata    (rdata0),
        .rsp_err      (err0),
        .busy         (busy0)
    );

    dmem_ctrl #(.DEPTH_WORDS(128), .RD_LAT(3)) u_lat3 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (valid3),
        .req_ready    (ready3),
        .req_we       (we),
        .req_addr     (addr),
        .req_wdata    (wdata),
        .req_size     (size),
        .req_unsigned (uns),
        .rsp_valid    (rvalid3),
        .rsp_rdata    (rdata3),
        .rsp_err      (err3),
        .busy         (busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input logic u);
        we    = w;
        addr  = a;
        wdata = d;
        size  = s;
        uns   = u;
    endtask

    // One transaction on the RD_LAT=0 instance: accept, response at T+1, idle at T+2.
    task automatic req0(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s, input logic u,
                        input logic [31:0] exp_rdata, input logic exp_err);
        set_req(w, a, d, s, u);
        valid0 = 1'b1;
        check({tag, "/ready"}, {31'd0, ready0}, 32'd1);
        tick();
        valid0 = 1'b0;
        check({tag, "/rsp_valid"}, {31'd0, rvalid0}, 32'd1);
        check({tag, "/rdata"}, rdata0, exp_rdata);
        check({tag, "/err"}, {31'd0, err0}, {31'd0, exp_err});
        check({tag, "/busy"}, {31'd0, busy0}, 32'd1);
        tick();
        check({tag, "/pulse_end"}, {31'd0, rvalid0}, 32'd0);
        check({tag, "/rdata_clr"}, rdata0, 32'd0);
        check({tag, "/err_clr"}, {31'd0, err0}, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        valid0 = 1'b0;
        valid3 = 1'b0;
        set_req(1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        check("rst/ready0", {31'd0, ready0}, 32'd1);
        check("rst/busy0", {31'd0, busy0}, 32'd0);
        check("rst/valid0", {31'd0, rvalid0}, 32'd0);
        check("rst/rdata0", rdata0, 32'd0);
        check("rst/err0", {31'd0, err0}, 32'd0);
        check("rst/ready3", {31'd0, ready3}, 32'd1);
        check("rst/valid3", {31'd0, rvalid3}, 32'd0);

        // RD_LAT=0 basic and sub-word accesses
        req0("sw10", 1'b1, 32'h10, 32'h8765_4321, 2'b10, 1'b0, 32'h0, 1'b0);
        req0("lw10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h8765_4321, 1'b0);
        req0("lb13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'hFFFF_FF87, 1'b0);
        req0("lbu13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h0000_0087, 1'b0);
        req0("lh12", 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 32'hFFFF_8765, 1'b0);
        req0("lhu10", 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 32'h0000_4321, 1'b0);
        req0("sb11", 1'b1, 32'h11, 32'hFFFF_FFAA, 2'b00, 1'b0, 32'h0, 1'b0);
        req0("sh12", 1'b1, 32'h12, 32'h1234_BEEF, 2'b01, 1'b0, 32'h0, 1'b0);
        req0("lw10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hBEEF_AA21, 1'b0);

        // Error cases
        req0("lw06", 1'b0, 32'h06, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        req0("sh11", 1'b1, 32'h11, 32'h0000_1234, 2'b01, 1'b0, 32'h0, 1'b1);
        req0("lw10c", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hBEEF_AA21, 1'b0);
        req0("lw200", 1'b0, 32'h200, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        req0("size11", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
        req0("sw200", 1'b1, 32'h8000_0010, 32'h5555_5555, 2'b10, 1'b0, 32'h0, 1'b1);
        req0("lw10d", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hBEEF_AA21, 1'b0);

        // RD_LAT=3: store latency is still one cycle
        set_req(1'b1, 32'h20, 32'hCAFE_F00D, 2'b10, 1'b0);
        valid3 = 1'b1;
        tick();
        valid3 = 1'b0;
        check("l3_sw/valid", {31'd0, rvalid3}, 32'd1);
        check("l3_sw/err", {31'd0, err3}, 32'd0);
        tick();
        check("l3_sw/ready", {31'd0, ready3}, 32'd1);

        // Load at T, second request held from T+1 until accepted
        set_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        valid3 = 1'b1;
        check("l3_T/ready", {31'd0, ready3}, 32'd1);
        tick();
        set_req(1'b0, 32'h21, 32'h0, 2'b00, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("l3_T+%0d/ready", c), {31'd0, ready3}, 32'd0);
            check($sformatf("l3_T+%0d/busy", c), {31'd0, busy3}, 32'd1);
            check($sformatf("l3_T+%0d/valid", c), {31'd0, rvalid3}, 32'd0);
            tick();
        end
        check("l3_T+4/valid", {31'd0, rvalid3}, 32'd1);
        check("l3_T+4/rdata", rdata3, 32'hCAFE_F00D);
        check("l3_T+4/err", {31'd0, err3}, 32'd0);
        check("l3_T+4/ready", {31'd0, ready3}, 32'd0);
        tick();
        check("l3_T+5/ready", {31'd0, ready3}, 32'd1);
        check("l3_T+5/valid", {31'd0, rvalid3}, 32'd0);
        check("l3_T+5/rdata", rdata3, 32'd0);
        tick();
        valid3 = 1'b0;
        for (int c = 6; c <= 8; c++) begin
            check($sformatf("l3_T+%0d/valid", c), {31'd0, rvalid3}, 32'd0);
            tick();
        end
        check("l3_2nd/valid", {31'd0, rvalid3}, 32'd1);
        check("l3_2nd/rdata", rdata3, 32'h0000_00F0);
        tick();
        check("l3_2nd/idle", {31'd0, ready3}, 32'd1);

        // Reset while a load is waiting
        set_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        valid3 = 1'b1;
        tick();
        valid3 = 1'b0;
        check("rst_mid/T+1_ready", {31'd0, ready3}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid/ready", {31'd0, ready3}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("rst_mid/no_rsp%0d", c), {31'd0, rvalid3}, 32'd0);
            tick();
        end
        set_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        valid3 = 1'b1;
        tick();
        valid3 = 1'b0;
        repeat (3) tick();
        check("rst_mid/reload_valid", {31'd0, rvalid3}, 32'd1);
        check("rst_mid/reload_rdata", rdata3, 32'hCAFE_F00D);
        tick();
        req0("post_rst_lw10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hBEEF_AA21, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
